// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if
// Bundles the decode issue/hazard-query signals, the two writeback requesters
// (A = ALU, B = LSU/MUL) and the register-file write port into one interface.
// The master side is whoever drives requests (decode plus execute/memory);
// the slave side is the scheduler itself.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;

    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic [ADDR_W-1:0] rf_wr_address;
    logic [DATA_W-1:0] rf_data;
    logic              rf_write_enable;

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  issue_ready, rs1_busy, rs2_busy,
        input  a_ready, b_ready,
        input  rf_wr_address, rf_data, rf_write_enable
    );

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output issue_ready, rs1_busy, rs2_busy,
        output a_ready, b_ready,
        output rf_wr_address, rf_data, rf_write_enable
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Shares the single register-file write port between a single-cycle ALU
// writeback (A) and a multi-cycle LSU/MUL writeback (B) with round-robin
// arbitration, and keeps a per-register busy scoreboard so decode can stall
// on RAW/WAW hazards. x0 is never busy and is never written.
// Optional feature: define RF_SCHED_PERF_EN to add two saturating 32-bit
// performance counters (requester conflicts, issue stalls) as extra ports.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    regfile_wb_scheduler_if.slave bus
`ifdef RF_SCHED_PERF_EN
    ,
    output logic [31:0]           o_perf_conflicts,
    output logic [31:0]           o_perf_issue_stalls
`endif
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e            r_lastGrant;
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W-1:0] r_rfAddr;
    logic [DATA_W-1:0] r_rfData;
    logic              r_rfWe;

    logic              w_grantA;
    logic              w_grantB;
    logic              w_issueReady;
    logic              w_issueFire;
    logic [NREG-1:0]   w_busyNext;

    // Round-robin grant: a lone requester always wins, on a conflict the one that did not win last time goes
    always_comb begin
        w_grantA = 1'b0;
        w_grantB = 1'b0;
        if (bus.a_valid && bus.b_valid) begin
            if (r_lastGrant == GRANT_B) begin
                w_grantA = 1'b1;
            end else begin
                w_grantB = 1'b1;
            end
        end else begin
            w_grantA = bus.a_valid;
            w_grantB = bus.b_valid;
        end
    end

    // The write port never back-pressures, so ready is exactly the grant
    assign bus.a_ready = w_grantA;
    assign bus.b_ready = w_grantB;

    // Hazard queries; x0 is forced clear so a stray bit can never stall on it
    assign w_issueReady = (bus.issue_rd == '0) || !r_busy[bus.issue_rd];
    assign bus.issue_ready = w_issueReady;
    assign bus.rs1_busy = (bus.rs1_addr != '0) && r_busy[bus.rs1_addr];
    assign bus.rs2_busy = (bus.rs2_addr != '0) && r_busy[bus.rs2_addr];
    assign w_issueFire = bus.issue_valid && w_issueReady && (bus.issue_rd != '0);

    // Next scoreboard: commit clears first, then a new issue sets, so set wins on the same index
    always_comb begin
        w_busyNext = r_busy;
        if (r_rfWe) begin
            w_busyNext[r_rfAddr] = 1'b0;
        end
        if (w_issueFire) begin
            w_busyNext[bus.issue_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // One-cycle write pipeline to the register file and the round-robin history
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rfAddr    <= '0;
            r_rfData    <= '0;
            r_rfWe      <= 1'b0;
            r_lastGrant <= GRANT_B;
        end else begin
            r_rfWe <= 1'b0;
            if (w_grantA) begin
                r_rfAddr    <= bus.a_rd;
                r_rfData    <= bus.a_data;
                r_rfWe      <= (bus.a_rd != '0);
                r_lastGrant <= GRANT_A;
            end else if (w_grantB) begin
                r_rfAddr    <= bus.b_rd;
                r_rfData    <= bus.b_data;
                r_rfWe      <= (bus.b_rd != '0);
                r_lastGrant <= GRANT_B;
            end
        end
    end

    assign bus.rf_wr_address   = r_rfAddr;
    assign bus.rf_data         = r_rfData;
    assign bus.rf_write_enable = r_rfWe;

`ifdef RF_SCHED_PERF_EN
    logic [31:0] r_perfConflicts;
    logic [31:0] r_perfIssueStalls;

    // Saturating event counters for requester conflicts and decode issue stalls
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_perfConflicts   <= '0;
            r_perfIssueStalls <= '0;
        end else begin
            if (bus.a_valid && bus.b_valid && (r_perfConflicts != '1)) begin
                r_perfConflicts <= r_perfConflicts + 32'd1;
            end
            if (bus.issue_valid && !w_issueReady && (r_perfIssueStalls != '1)) begin
                r_perfIssueStalls <= r_perfIssueStalls + 32'd1;
            end
        end
    end

    assign o_perf_conflicts    = r_perfConflicts;
    assign o_perf_issue_stalls = r_perfIssueStalls;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler
// Directed scenarios for reset, single writeback, round-robin conflicts,
// scoreboard hazards, x0 handling and reset mid-write, followed by a
// randomized run checked against a behavioural model of the scheduler.
// Define RF_SCHED_PERF_EN to also check the performance counters.
module tb_regfile_wb_scheduler;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef RF_SCHED_PERF_EN
    logic [31:0] perfConflicts;
    logic [31:0] perfIssueStalls;
`endif

    regfile_wb_scheduler #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREG  (NREG)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
`ifdef RF_SCHED_PERF_EN
        ,
        .o_perf_conflicts   (perfConflicts),
        .o_perf_issue_stalls(perfIssueStalls)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.a_valid     = 1'b0;
        bus.a_rd        = '0;
        bus.a_data      = '0;
        bus.b_valid     = 1'b0;
        bus.b_rd        = '0;
        bus.b_data      = '0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        idleInputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idleInputs();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd3;
        bus.a_data  = 32'h1234_5678;
        tick();
        tick();
        nCompared++;
        if (bus.rf_write_enable !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_we: got %0b expected 0", bus.rf_write_enable);
        end
        nCompared++;
        if (bus.rf_wr_address !== 5'd0 || bus.rf_data !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_rf: got addr %0d data %h expected 0/0", bus.rf_wr_address, bus.rf_data);
        end
        for (int i = 0; i < NREG; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(NREG - 1 - i);
            #1;
            nCompared++;
            if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_busy[%0d]: got %0b%0b expected 00", i, bus.rs1_busy, bus.rs2_busy);
            end
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if (bus.a_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_a_ready: got %0b expected 1", bus.a_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        nCompared++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_wr_address !== 5'd3 || bus.rf_data !== 32'h1234_5678) begin
            nMismatched++;
            $display("[TB] FAIL reset_first_write: got we %0b addr %0d data %h expected 1/3/12345678",
                     bus.rf_write_enable, bus.rf_wr_address, bus.rf_data);
        end
    endtask

    task automatic test_single_a();
        doReset();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd5;
        bus.a_data  = 32'hDEAD_BEEF;
        #1;
        nCompared++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_ready: got a %0b b %0b expected 1/0", bus.a_ready, bus.b_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        nCompared++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_wr_address !== 5'd5 || bus.rf_data !== 32'hDEAD_BEEF) begin
            nMismatched++;
            $display("[TB] FAIL single_write: got we %0b addr %0d data %h expected 1/5/deadbeef",
                     bus.rf_write_enable, bus.rf_wr_address, bus.rf_data);
        end
        tick();
        nCompared++;
        if (bus.rf_write_enable !== 1'b0 || bus.rf_wr_address !== 5'd5 || bus.rf_data !== 32'hDEAD_BEEF) begin
            nMismatched++;
            $display("[TB] FAIL single_hold: got we %0b addr %0d data %h expected 0/5/deadbeef",
                     bus.rf_write_enable, bus.rf_wr_address, bus.rf_data);
        end
    endtask

    task automatic test_conflict();
        logic [2:0] expAWins;
        logic [ADDR_W-1:0] expAddr;
        expAWins = 3'b101;
        doReset();
        bus.a_rd   = 5'd1;
        bus.a_data = 32'd1;
        bus.b_rd   = 5'd2;
        bus.b_data = 32'd2;
        for (int i = 0; i < 3; i++) begin
            bus.a_valid = 1'b1;
            bus.b_valid = 1'b1;
            #1;
            nCompared++;
            if (bus.a_ready !== expAWins[2-i] || bus.b_ready !== !expAWins[2-i]) begin
                nMismatched++;
                $display("[TB] FAIL conflict_grant[%0d]: got a %0b b %0b expected a %0b", i, bus.a_ready, bus.b_ready, expAWins[2-i]);
            end
            tick();
            expAddr = expAWins[2-i] ? 5'd1 : 5'd2;
            nCompared++;
            if (bus.rf_write_enable !== 1'b1 || bus.rf_wr_address !== expAddr || bus.rf_data !== 32'(expAddr)) begin
                nMismatched++;
                $display("[TB] FAIL conflict_write[%0d]: got we %0b addr %0d data %h expected 1/%0d",
                         i, bus.rf_write_enable, bus.rf_wr_address, bus.rf_data, expAddr);
            end
        end
        idleInputs();
    endtask

    task automatic test_scoreboard();
        doReset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        #1;
        nCompared++;
        if (bus.issue_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sb_first_issue: got %0b expected 1", bus.issue_ready);
        end
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd7;
        bus.rs2_addr    = 5'd7;
        #1;
        nCompared++;
        if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sb_raw: got %0b%0b expected 11", bus.rs1_busy, bus.rs2_busy);
        end
        bus.issue_valid = 1'b1;
        #1;
        nCompared++;
        if (bus.issue_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sb_waw: got %0b expected 0", bus.issue_ready);
        end
        bus.issue_valid = 1'b0;
        bus.b_valid     = 1'b1;
        bus.b_rd        = 5'd7;
        bus.b_data      = 32'h0000_0077;
        #1;
        nCompared++;
        if (bus.b_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sb_b_ready: got %0b expected 1", bus.b_ready);
        end
        tick();
        bus.b_valid = 1'b0;
        nCompared++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_wr_address !== 5'd7 || bus.rs1_busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sb_commit_cycle: got we %0b addr %0d busy %0b expected 1/7/1",
                     bus.rf_write_enable, bus.rf_wr_address, bus.rs1_busy);
        end
        tick();
        nCompared++;
        if (bus.rf_write_enable !== 1'b0 || bus.rs1_busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sb_cleared: got we %0b busy %0b expected 0/0", bus.rf_write_enable, bus.rs1_busy);
        end
        // write to a non-busy register while decode issues the same register: set must win
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd9;
        bus.a_data  = 32'h0000_0099;
        tick();
        bus.a_valid     = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.rs1_addr    = 5'd9;
        #1;
        nCompared++;
        if (bus.issue_ready !== 1'b1 || bus.rf_write_enable !== 1'b1 || bus.rs1_busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sb_nonbusy_write: got ready %0b we %0b busy %0b expected 1/1/0",
                     bus.issue_ready, bus.rf_write_enable, bus.rs1_busy);
        end
        tick();
        bus.issue_valid = 1'b0;
        #1;
        nCompared++;
        if (bus.rs1_busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sb_set_wins: got %0b expected 1", bus.rs1_busy);
        end
    endtask

    task automatic test_x0();
        doReset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        #1;
        nCompared++;
        if (bus.issue_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL x0_issue_ready: got %0b expected 1", bus.issue_ready);
        end
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd0;
        bus.rs2_addr    = 5'd0;
        bus.a_valid     = 1'b1;
        bus.a_rd        = 5'd0;
        bus.a_data      = 32'hFFFF_FFFF;
        #1;
        nCompared++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.a_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL x0_query: got busy %0b%0b a_ready %0b expected 00/1", bus.rs1_busy, bus.rs2_busy, bus.a_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        nCompared++;
        if (bus.rf_write_enable !== 1'b0 || bus.rf_wr_address !== 5'd0 || bus.rf_data !== 32'hFFFF_FFFF) begin
            nMismatched++;
            $display("[TB] FAIL x0_write: got we %0b addr %0d data %h expected 0/0/ffffffff",
                     bus.rf_write_enable, bus.rf_wr_address, bus.rf_data);
        end
    endtask

    task automatic test_reset_mid_write();
        doReset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd13;
        tick();
        bus.issue_valid = 1'b0;
        bus.a_valid     = 1'b1;
        bus.a_rd        = 5'd12;
        bus.a_data      = 32'hCAFE_0012;
        bus.b_valid     = 1'b1;
        bus.b_rd        = 5'd14;
        bus.b_data      = 32'hCAFE_0014;
        tick();
        nCompared++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_wr_address !== 5'd12) begin
            nMismatched++;
            $display("[TB] FAIL midrst_grant: got we %0b addr %0d expected 1/12", bus.rf_write_enable, bus.rf_wr_address);
        end
        rst = 1'b0;
        idleInputs();
        tick();
        rst = 1'b1;
        bus.rs1_addr = 5'd13;
        bus.rs2_addr = 5'd12;
        #1;
        nCompared++;
        if (bus.rf_write_enable !== 1'b0 || bus.rf_wr_address !== 5'd0 || bus.rf_data !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_rf: got we %0b addr %0d data %h expected 0/0/0",
                     bus.rf_write_enable, bus.rf_wr_address, bus.rf_data);
        end
        nCompared++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_busy: got %0b%0b expected 00", bus.rs1_busy, bus.rs2_busy);
        end
`ifdef RF_SCHED_PERF_EN
        nCompared++;
        if (perfConflicts !== 32'd0 || perfIssueStalls !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_perf: got %0d/%0d expected 0/0", perfConflicts, perfIssueStalls);
        end
`endif
    endtask

    // Randomized traffic against a behavioural model: busy set per register,
    // who won the last transfer, and what the write port should present.
    task automatic test_random(input int nCycles);
        bit                mBusy [NREG];
        bit                mLastWasA;
        logic              mWe;
        logic [ADDR_W-1:0] mAddr;
        logic [DATA_W-1:0] mData;
        logic              expA;
        logic              expB;
        logic              expIssueReady;
        logic              expRs1;
        logic              expRs2;
        int                mConf;
        int                mStall;
        doReset();
        for (int r = 0; r < NREG; r++) mBusy[r] = 1'b0;
        mLastWasA = 1'b0;
        mWe       = 1'b0;
        mAddr     = '0;
        mData     = '0;
        mConf     = 0;
        mStall    = 0;
        for (int c = 0; c < nCycles; c++) begin
            if (!bus.a_valid && ($urandom_range(0, 99) < 55)) begin
                bus.a_valid = 1'b1;
                bus.a_rd    = 5'($urandom_range(0, 7));
                bus.a_data  = $urandom;
            end
            if (!bus.b_valid && ($urandom_range(0, 99) < 45)) begin
                bus.b_valid = 1'b1;
                bus.b_rd    = 5'($urandom_range(0, 7));
                bus.b_data  = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 99) < 40);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.rs1_addr    = 5'($urandom_range(0, 7));
            bus.rs2_addr    = 5'($urandom_range(0, 7));
            #2;
            if (bus.a_valid && bus.b_valid) begin
                expA = !mLastWasA;
                expB = mLastWasA;
            end else begin
                expA = bus.a_valid;
                expB = bus.b_valid;
            end
            expIssueReady = (bus.issue_rd == 0) || !mBusy[bus.issue_rd];
            expRs1 = (bus.rs1_addr != 0) && mBusy[bus.rs1_addr];
            expRs2 = (bus.rs2_addr != 0) && mBusy[bus.rs2_addr];
            nCompared++;
            if (bus.a_ready !== expA || bus.b_ready !== expB) begin
                nMismatched++;
                $display("[TB] FAIL rand_grant@%0d: got a %0b b %0b expected a %0b b %0b", c, bus.a_ready, bus.b_ready, expA, expB);
            end
            nCompared++;
            if (bus.issue_ready !== expIssueReady || bus.rs1_busy !== expRs1 || bus.rs2_busy !== expRs2) begin
                nMismatched++;
                $display("[TB] FAIL rand_hazard@%0d: got rdy %0b rs1 %0b rs2 %0b expected %0b %0b %0b",
                         c, bus.issue_ready, bus.rs1_busy, bus.rs2_busy, expIssueReady, expRs1, expRs2);
            end
            if (bus.a_valid && bus.b_valid) mConf++;
            if (bus.issue_valid && !expIssueReady) mStall++;
            if (mWe) mBusy[mAddr] = 1'b0;
            if (bus.issue_valid && expIssueReady && bus.issue_rd != 0) mBusy[bus.issue_rd] = 1'b1;
            if (expA) begin
                mAddr     = bus.a_rd;
                mData     = bus.a_data;
                mWe       = (bus.a_rd != 0);
                mLastWasA = 1'b1;
            end else if (expB) begin
                mAddr     = bus.b_rd;
                mData     = bus.b_data;
                mWe       = (bus.b_rd != 0);
                mLastWasA = 1'b0;
            end else begin
                mWe = 1'b0;
            end
            tick();
            if (expA) bus.a_valid = 1'b0;
            if (expB) bus.b_valid = 1'b0;
            nCompared++;
            if (bus.rf_write_enable !== mWe || bus.rf_wr_address !== mAddr || bus.rf_data !== mData) begin
                nMismatched++;
                $display("[TB] FAIL rand_write@%0d: got we %0b addr %0d data %h expected %0b %0d %h",
                         c, bus.rf_write_enable, bus.rf_wr_address, bus.rf_data, mWe, mAddr, mData);
            end
`ifdef RF_SCHED_PERF_EN
            nCompared++;
            if (perfConflicts !== 32'(mConf) || perfIssueStalls !== 32'(mStall)) begin
                nMismatched++;
                $display("[TB] FAIL rand_perf@%0d: got %0d/%0d expected %0d/%0d", c, perfConflicts, perfIssueStalls, mConf, mStall);
            end
`endif
        end
        idleInputs();
    endtask

    // Scenario sequence and summary
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b0;
        idleInputs();
        test_reset();
        test_single_a();
        test_conflict();
        test_scoreboard();
        test_x0();
        test_reset_mid_write();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
